// File: rtl/stopwatch_pkg.sv
// Shared types and helpers for the two-digit BCD stopwatch controller.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    SPLIT = 2'd3
  } state_t;

  localparam logic [3:0] BCD_MAX = 4'd9;

  // Prescaler needs at least one bit even when DIV is 1.
  function automatic int presc_width(input int div);
    int w;
    w = $clog2(div);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/stopwatch_ctrl_bcd_digit.sv
// One BCD digit register: clear, increment on enable, carry out when rolling 9 -> 0.
module bcd_digit
  import stopwatch_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       en,
  output logic [3:0] digit,
  output logic [3:0] nxt,
  output logic       carry
);

  // nxt is exported so the owner can register a display copy in the same edge.
  always_comb begin
    nxt = digit;
    if (clr)
      nxt = 4'd0;
    else if (en)
      nxt = (digit == BCD_MAX) ? 4'd0 : digit + 4'd1;
  end

  assign carry = en && (digit == BCD_MAX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      digit <= 4'd0;
    else
      digit <= nxt;
  end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Two-digit BCD stopwatch: tick prescaler, digit cascade, lap/split latch and sequencing FSM.
//   state | meaning
//   IDLE  | cleared, waiting for start
//   RUN   | counting, display shows live count
//   PAUSE | count and prescaler frozen
//   SPLIT | counting, display frozen at lap value
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int DIV  = 10,
  parameter bit WRAP = 1'b1
) (
  input  logic       CLK0,
  input  logic       RST,
  input  logic       SS,
  input  logic       CLR,
  input  logic       LAP,
  output logic [3:0] DIG0,
  output logic [3:0] DIG1,
  output logic       RUNNING,
  output logic       LAPPED,
  output logic       OVF
);

  localparam int            PW         = presc_width(DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);

  state_t        state;
  state_t        state_nxt;
  logic [PW-1:0] presc;
  logic [PW-1:0] presc_nxt;
  logic [3:0]    units;
  logic [3:0]    tens;
  logic [3:0]    units_nxt;
  logic [3:0]    tens_nxt;
  logic [3:0]    lap_units;
  logic [3:0]    lap_tens;
  logic [3:0]    disp_units_nxt;
  logic [3:0]    disp_tens_nxt;
  logic          counting;
  logic          tick;
  logic          at_max;
  logic          sat_tick;
  logic          units_en;
  logic          units_carry;
  logic          tens_carry;
  logic          ovf_nxt;
  logic          lap_take;
  logic          clr_cnt;
  logic          running_nxt;
  logic          lapped_nxt;

  assign counting = (state == RUN) || (state == SPLIT);
  assign tick     = counting && (presc == PRESC_LAST);
  assign at_max   = (units == BCD_MAX) && (tens == BCD_MAX);
  // In saturate mode the 99 tick freezes the digits instead of rolling them.
  assign sat_tick = tick && at_max && !WRAP;
  assign units_en = tick && !sat_tick;
  assign ovf_nxt  = tens_carry || sat_tick;

  always_ff @(posedge CLK0 or posedge RST) begin
    if (RST)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (SS) state_nxt = RUN;
      RUN:     if (SS) state_nxt = PAUSE; else if (LAP) state_nxt = SPLIT;
      SPLIT:   if (SS) state_nxt = PAUSE; else if (LAP) state_nxt = RUN;
      PAUSE:   if (CLR) state_nxt = IDLE; else if (SS) state_nxt = RUN;
      default: state_nxt = IDLE;
    endcase
    if (sat_tick)
      state_nxt = PAUSE;
  end

  always_comb begin
    lap_take    = (state == RUN) && (state_nxt == SPLIT);
    clr_cnt     = (state == PAUSE) && (state_nxt == IDLE);
    running_nxt = (state_nxt == RUN) || (state_nxt == SPLIT);
    lapped_nxt  = (state_nxt == SPLIT);
  end

  always_comb begin
    presc_nxt = presc;
    if (clr_cnt)
      presc_nxt = '0;
    else if (counting)
      presc_nxt = tick ? '0 : presc + PW'(1);
  end

  always_ff @(posedge CLK0 or posedge RST) begin
    if (RST)
      presc <= '0;
    else
      presc <= presc_nxt;
  end

  bcd_digit u_units (
    .clk   (CLK0),
    .rst   (RST),
    .clr   (clr_cnt),
    .en    (units_en),
    .digit (units),
    .nxt   (units_nxt),
    .carry (units_carry)
  );

  bcd_digit u_tens (
    .clk   (CLK0),
    .rst   (RST),
    .clr   (clr_cnt),
    .en    (units_carry),
    .digit (tens),
    .nxt   (tens_nxt),
    .carry (tens_carry)
  );

  // The lap value is the pre-edge live count, even when a tick lands on the LAP edge.
  always_ff @(posedge CLK0 or posedge RST) begin
    if (RST) begin
      lap_units <= 4'd0;
      lap_tens  <= 4'd0;
    end else if (lap_take) begin
      lap_units <= units;
      lap_tens  <= tens;
    end
  end

  always_comb begin
    disp_units_nxt = units_nxt;
    disp_tens_nxt  = tens_nxt;
    if (state_nxt == SPLIT) begin
      disp_units_nxt = lap_take ? units : lap_units;
      disp_tens_nxt  = lap_take ? tens  : lap_tens;
    end
  end

  always_ff @(posedge CLK0 or posedge RST) begin
    if (RST) begin
      DIG0    <= 4'd0;
      DIG1    <= 4'd0;
      RUNNING <= 1'b0;
      LAPPED  <= 1'b0;
      OVF     <= 1'b0;
    end else begin
      DIG0    <= disp_units_nxt;
      DIG1    <= disp_tens_nxt;
      RUNNING <= running_nxt;
      LAPPED  <= lapped_nxt;
      OVF     <= ovf_nxt;
    end
  end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench: four stopwatch configurations share one command stream; an integer model checks every cycle.
module tb_stopwatch_ctrl;

  localparam int NI = 4;
  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_PAUSE = 2;
  localparam int M_SPLIT = 3;

  function automatic int div_of(input int i);
    case (i)
      0:       return 4;
      1:       return 1;
      2:       return 1;
      default: return 2;
    endcase
  endfunction

  function automatic bit wrap_of(input int i);
    return (i == 2) ? 1'b0 : 1'b1;
  endfunction

  typedef struct packed {
    int mode;
    int cnt;
    int pre;
    int lat;
    bit ovf;
  } mst_t;

  logic       CLK0 = 1'b0;
  logic       RST  = 1'b0;
  logic       SS   = 1'b0;
  logic       CLR  = 1'b0;
  logic       LAP  = 1'b0;
  logic [3:0] d0  [NI];
  logic [3:0] d1  [NI];
  logic       run [NI];
  logic       lpd [NI];
  logic       ovf [NI];

  int   checks = 0;
  int   errors = 0;
  mst_t ms [NI];

  always #5 CLK0 = ~CLK0;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    stopwatch_ctrl #(.DIV(div_of(g)), .WRAP(wrap_of(g))) dut (
      .CLK0    (CLK0),
      .RST     (RST),
      .SS      (SS),
      .CLR     (CLR),
      .LAP     (LAP),
      .DIG0    (d0[g]),
      .DIG1    (d1[g]),
      .RUNNING (run[g]),
      .LAPPED  (lpd[g]),
      .OVF     (ovf[g])
    );
  end

  // Behavioural stopwatch: count is a plain integer 0..99, prescaler an integer period counter.
  function automatic mst_t mstep(input mst_t s, input int dv, input bit wr,
                                 input bit ss_i, input bit clr_i, input bit lap_i);
    mst_t n;
    bit   live;
    n = s;
    n.ovf = 1'b0;
    live = (s.mode == M_RUN) || (s.mode == M_SPLIT);
    case (s.mode)
      M_IDLE:  if (ss_i) n.mode = M_RUN;
      M_RUN:   if (ss_i) n.mode = M_PAUSE;
               else if (lap_i) begin n.mode = M_SPLIT; n.lat = s.cnt; end
      M_SPLIT: if (ss_i) n.mode = M_PAUSE; else if (lap_i) n.mode = M_RUN;
      default: if (clr_i) begin n.mode = M_IDLE; n.cnt = 0; n.pre = 0; end
               else if (ss_i) n.mode = M_RUN;
    endcase
    if (live) begin
      if (s.pre == dv - 1) begin
        n.pre = 0;
        if (s.cnt == 99) begin
          n.ovf = 1'b1;
          if (wr) n.cnt = 0;
          else    n.mode = M_PAUSE;
        end else begin
          n.cnt = s.cnt + 1;
        end
      end else begin
        n.pre = s.pre + 1;
      end
    end
    return n;
  endfunction

  always @(posedge CLK0 or posedge RST) begin
    for (int i = 0; i < NI; i++) begin
      if (RST) ms[i] <= '0;
      else     ms[i] <= mstep(ms[i], div_of(i), wrap_of(i), SS, CLR, LAP);
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge CLK0) begin
    if (!RST) begin
      for (int i = 0; i < NI; i++) begin
        int shown;
        shown = (ms[i].mode == M_SPLIT) ? ms[i].lat : ms[i].cnt;
        chk($sformatf("u%0d_dig0", i), int'(d0[i]), shown % 10);
        chk($sformatf("u%0d_dig1", i), int'(d1[i]), shown / 10);
        chk($sformatf("u%0d_running", i), int'(run[i]),
            int'((ms[i].mode == M_RUN) || (ms[i].mode == M_SPLIT)));
        chk($sformatf("u%0d_lapped", i), int'(lpd[i]), int'(ms[i].mode == M_SPLIT));
        chk($sformatf("u%0d_ovf", i), int'(ovf[i]), int'(ms[i].ovf));
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge CLK0);
    #1;
  endtask

  // Inputs are set just after an edge and sampled on the next one.
  task automatic cmd(input bit s, input bit c, input bit l);
    SS = s; CLR = c; LAP = l;
    @(posedge CLK0);
    #1;
    SS = 1'b0; CLR = 1'b0; LAP = 1'b0;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    @(posedge CLK0);
    @(posedge CLK0);
    #1;
    RST = 1'b0;
  endtask

  initial begin
    #1;
    do_reset();
    chk("rst_dig0", int'(d0[0]), 0);
    chk("rst_running", int'(run[0]), 0);

    // start, DIV=4: first increment four edges after SS
    cmd(1, 0, 0);
    chk("a_running", int'(run[0]), 1);
    chk("a_dig0_e0", int'(d0[0]), 0);
    step(3);
    chk("a_dig0_e3", int'(d0[0]), 0);
    step(1);
    chk("a_dig0_e4", int'(d0[0]), 1);
    step(4);
    chk("a_dig0_e8", int'(d0[0]), 2);

    // carry and wrap (u1) alongside saturate (u2), DIV=1
    do_reset();
    cmd(1, 0, 0);
    step(9);
    chk("b_dig_09", int'(d1[1]) * 10 + int'(d0[1]), 9);
    step(1);
    chk("b_dig_10", int'(d1[1]) * 10 + int'(d0[1]), 10);
    step(89);
    chk("b_dig_99", int'(d1[1]) * 10 + int'(d0[1]), 99);
    chk("c_run_99", int'(run[2]), 1);
    step(1);
    chk("b_wrap_dig", int'(d1[1]) * 10 + int'(d0[1]), 0);
    chk("b_wrap_ovf", int'(ovf[1]), 1);
    chk("b_wrap_run", int'(run[1]), 1);
    chk("c_sat_dig", int'(d1[2]) * 10 + int'(d0[2]), 99);
    chk("c_sat_ovf", int'(ovf[2]), 1);
    chk("c_sat_run", int'(run[2]), 0);
    step(1);
    chk("b_ovf_once", int'(ovf[1]), 0);
    chk("b_dig_01", int'(d0[1]), 1);
    chk("c_ovf_once", int'(ovf[2]), 0);
    chk("c_hold_99", int'(d1[2]) * 10 + int'(d0[2]), 99);

    // split on u3, DIV=2
    do_reset();
    cmd(1, 0, 0);
    step(10);
    chk("d_live_05", int'(d0[3]), 5);
    cmd(0, 0, 1);
    chk("d_lapped", int'(lpd[3]), 1);
    step(13);
    chk("d_frozen", int'(d1[3]) * 10 + int'(d0[3]), 5);
    chk("d_still_lapped", int'(lpd[3]), 1);
    cmd(0, 0, 1);
    chk("d_release", int'(d1[3]) * 10 + int'(d0[3]), 12);
    chk("d_unlapped", int'(lpd[3]), 0);

    // pause mid-period, resume, clear on u0, DIV=4
    do_reset();
    cmd(1, 0, 0);
    step(1);
    cmd(1, 0, 0);
    chk("e_paused", int'(run[0]), 0);
    step(10);
    cmd(1, 0, 0);
    chk("e_resume_dig", int'(d0[0]), 0);
    step(1);
    chk("e_resume_p1", int'(d0[0]), 0);
    step(1);
    chk("e_resume_p2", int'(d0[0]), 1);
    cmd(1, 0, 0);
    cmd(0, 1, 0);
    chk("e_clear_dig", int'(d0[0]), 0);
    chk("e_clear_run", int'(run[0]), 0);

    // priority and ignored commands, mostly u1 (DIV=1)
    cmd(1, 0, 0);
    step(5);
    cmd(1, 0, 0);
    chk("f_paused_6", int'(d0[1]), 6);
    cmd(1, 1, 1);
    chk("f_all_clr", int'(d0[1]), 0);
    chk("f_all_run", int'(run[1]), 0);
    cmd(1, 0, 0);
    step(2);
    cmd(1, 0, 1);
    chk("f_sslap_run", int'(run[1]), 0);
    chk("f_sslap_lap", int'(lpd[1]), 0);
    chk("f_sslap_dig", int'(d0[1]), 3);
    cmd(1, 0, 0);
    cmd(0, 1, 0);
    chk("f_clr_in_run", int'(run[1]), 1);
    chk("f_clr_dig", int'(d0[1]), 4);

    // asynchronous reset while in SPLIT
    cmd(0, 0, 1);
    chk("g_split", int'(lpd[0]), 1);
    step(3);
    #3;
    RST = 1'b1;
    #1;
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("g_rst_out_u%0d", i),
          int'(d0[i]) + int'(d1[i]) + int'(run[i]) + int'(lpd[i]) + int'(ovf[i]), 0);
    end
    @(posedge CLK0);
    #1;
    RST = 1'b0;
    step(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/stopwatch_ctrl.md
# stopwatch_ctrl

Two-digit BCD stopwatch controller that sequences a seconds counter (00–99) from one-cycle start/stop, clear and lap commands. It divides CLK0 into a count tick, runs the digit cascade, and freezes the displayed value on lap (split) while counting continues. It sits between the debounced button front end and the seven-segment display drivers.

## Interface
- DIV, 10: CLK0 cycles per count tick; legal range ≥ 1.
- WRAP, 1: 1 = 99 wraps to 00; 0 = saturate at 99 and pause.
- CLK0  in  1  rising-edge clock.
- RST  in  1  asynchronous, active-high reset.
- SS  in  1  start/stop command, one-cycle pulse, synchronous to CLK0.
- CLR  in  1  clear command, one-cycle pulse.
- LAP  in  1  lap/split command, one-cycle pulse.
- DIG0  out  4  displayed units digit, BCD 0–9.
- DIG1  out  4  displayed tens digit, BCD 0–9.
- RUNNING  out  1  high in RUN or SPLIT.
- LAPPED  out  1  high in SPLIT.
- OVF  out  1  one-cycle pulse on the 99→next tick.

## Operation
- States: IDLE, RUN, PAUSE, SPLIT.
- IDLE: count = 00, prescaler = 0. SS → RUN. CLR and LAP ignored.
- RUN: SS → PAUSE. LAP → SPLIT, latching the display. CLR ignored.
- SPLIT: LAP → RUN, releasing the display to the live count. SS → PAUSE, also releasing. CLR ignored.
- PAUSE: SS → RUN. CLR → IDLE, clearing count and prescaler. LAP ignored.
- Priority on simultaneous commands: CLR > SS > LAP. A command ignored in the current state does not block a lower-priority command.
- Prescaler 0..DIV-1 advances only in RUN or SPLIT.
  - Holds in PAUSE, so a resume continues mid-period.
  - Tick = prescaler == DIV-1 while counting; the prescaler returns to 0 on that edge.
- Count on tick:
  - DIG0 9→0 carries into the tens digit; otherwise units +1.
  - At 99, WRAP=1: next = 00, OVF pulses, state is unchanged.
  - At 99, WRAP=0: count holds 99, OVF pulses, state → PAUSE from RUN or SPLIT.
- Latched value = live count visible in the cycle LAP is sampled, i.e. the pre-edge value, even if a tick lands on that edge.
- DIG0/DIG1 show the latched value in SPLIT and the live count in every other state.
- SS that leaves RUN/SPLIT on a tick edge: the tick still counts on that edge.

## Timing
- All outputs are registered.
- Reset values: state IDLE, DIG0 = 0, DIG1 = 0, RUNNING = 0, LAPPED = 0, OVF = 0, prescaler = 0, latch = 00.
- RST is asynchronous and takes effect mid-period, mid-split or mid-overflow. No tick or OVF issues in the cycle of reset release.
- Command sampled at edge N → state and RUNNING/LAPPED updated after edge N.
- From IDLE, SS sampled at edge N gives the first increment at edge N+DIV, then every DIV edges while counting.
- DIV=1: a tick on every counting edge.
- OVF is high for exactly the cycle following the 99 tick edge, coincident with DIG = 00 (WRAP=1) or 99 (WRAP=0).
- Command latency is one edge, with no handshake. Back-to-back pulses on consecutive cycles are each honoured.

## Structure
- Shared package stopwatch_pkg:
  - state enum (IDLE, RUN, PAUSE, SPLIT);
  - BCD_MAX = 4'd9;
  - prescaler-width function, max(1, clog2(DIV)).
- Sub-module bcd_digit: 4-bit BCD register with clear, enable in, carry out (digit == 9 && enable). Two instances are cascaded inside stopwatch_ctrl.
- The FSM, prescaler, lap latch and output registers live in stopwatch_ctrl.

## Test plan
- Reset/start, DIV=4: RST pulse, then SS at edge 0 → DIG=00 through edge 3; DIG0=1 after edge 4, 2 after edge 8; RUNNING=1 from edge 0.
- Carry and wrap, DIV=1, WRAP=1: run 100 edges from 00 → DIG 09→10 carry seen; after the 100th tick DIG=00 with OVF high one cycle, RUNNING stays 1.
- Saturate, DIV=1, WRAP=0: run to 99 → DIG holds 99, OVF one cycle, state PAUSE, RUNNING=0.
- Split: DIV=2, LAP at count 05 → DIG frozen at 05 and LAPPED=1 while the live count advances; LAP at live 12 → DIG=12 next cycle, LAPPED=0.
- Pause/resume/clear, DIV=4: SS after 2 prescaler cycles, wait 10 cycles, SS → next increment exactly 2 edges later. Then SS, CLR → DIG=00, IDLE.
- Priority and ignore: CLR+SS+LAP together in PAUSE → IDLE. SS+LAP in RUN → PAUSE, LAPPED=0. CLR in RUN → no effect. RST asserted mid-SPLIT → all outputs 0 immediately.
